c_boot_ctrl: RTL
================

C_BOOT_CTRL -- requirements
Module: c_boot_ctrl

Interface
REQ-001 SHALL have parameter RST_CYCLES, default 2: number of cycles o_c_core_reset is held after load (legal range 1..15).
REQ-002 SHALL have parameter MAX_WORDS, default 64: instruction-memory depth in words.
REQ-003 SHALL have one clock; reset is synchronous and active-high: i_c_sys_clock  in  1  system clock, all logic on rising edge.
REQ-004 SHALL have i_c_sys_reset  in  1  synchronous active-high reset.
REQ-005 SHALL have i_start  in  1  begin load session; sampled in IDLE or DONE only.
REQ-006 SHALL have i_word_count  in  7  words to load, legal 1..MAX_WORDS; sampled with i_start.
REQ-007 SHALL have i_run_cycles  in  16  normal-mode cycle budget; 0 = unlimited; sampled with i_start.
REQ-008 SHALL have i_abort  in  1  cancel current session.
REQ-009 SHALL have i_byte  in  8  program byte stream.
REQ-010 SHALL have i_byte_valid  in  1  i_byte valid.
REQ-011 SHALL have o_byte_ready  out  1  byte accepted when valid and ready both high.
REQ-012 SHALL have o_c_write_ins  out  32  assembled instruction word to core.
REQ-013 SHALL have o_c_ins_wr  out  1  one-cycle write strobe to core instruction memory.
REQ-014 SHALL have o_c_core_reset  out  1  reset to core.
REQ-015 SHALL have o_busy  out  1  high in LOAD, RESET_CORE, RUN.
REQ-016 SHALL have o_done  out  1  high in DONE.
REQ-017 SHALL have o_err  out  1  sticky session error; cleared by an accepted i_start.
REQ-018 SHALL have o_words_loaded  out  7  words written this session.
REQ-019 SHALL have o_cycle_count  out  16  cycles spent in RUN, saturating at 16'hFFFF.

Function
REQ-020 SHALL implement states IDLE, LOAD, RESET_CORE, RUN, DONE; all outputs registered.
REQ-021 SHALL, in IDLE/DONE on i_start, with i_word_count in 1..MAX_WORDS: clear counters and o_err, latch i_word_count and i_run_cycles, enter LOAD next cycle.
REQ-022 SHALL, on i_start with i_word_count 0 or above MAX_WORDS: set o_err, stay in (or return to) IDLE.
REQ-023 SHALL drive o_byte_ready high only in LOAD, including the cycle o_c_ins_wr is high.
REQ-024 SHALL assemble words little-endian: 1st accepted byte to bits [7:0], 4th to [31:24].
REQ-025 SHALL, on the cycle after the 4th byte is accepted, drive o_c_ins_wr high for exactly one cycle with the complete word on o_c_write_ins, and increment o_words_loaded the same cycle.
REQ-026 SHALL hold o_c_write_ins at its last value when o_c_ins_wr is low.
REQ-027 SHALL, in the cycle after the final word strobe, deassert o_byte_ready and enter RESET_CORE; no further bytes are accepted.
REQ-028 SHALL hold o_c_core_reset high for exactly RST_CYCLES cycles in RESET_CORE, then enter RUN with o_c_core_reset low.
REQ-029 SHALL keep o_c_core_reset low in IDLE, LOAD, RUN, DONE.
REQ-030 SHALL increment o_cycle_count each RUN cycle; when i_run_cycles is nonzero and o_cycle_count reaches it, enter DONE next cycle.
REQ-031 SHALL, on i_abort in LOAD: discard the partial word, issue no strobe, set o_err, enter IDLE.
REQ-032 SHALL, on i_abort in RUN: enter DONE with o_err clear; i_abort in IDLE, RESET_CORE, DONE is ignored.
REQ-033 SHALL give i_abort priority over a byte handshake or run-budget completion in the same cycle.
REQ-034 SHALL ignore i_start in LOAD, RESET_CORE, RUN.

Reset
REQ-035 SHALL, on i_c_sys_reset, enter IDLE within one clock regardless of state, including mid-word or mid-RUN.
REQ-036 SHALL, on reset, set o_c_core_reset=1 for the reset cycle(s), and o_byte_ready=0, o_c_ins_wr=0, o_c_write_ins=0, o_busy=0, o_done=0, o_err=0, o_words_loaded=0, o_cycle_count=0, byte index=0.
REQ-037 SHALL deassert o_c_core_reset on the first clock after i_c_sys_reset falls.

Verification
REQ-038 SHALL cover basic load: start, count 2, run 10; bytes 13,00,08,20,FF,FF,01,24 back-to-back -> strobes with 32'h20080013 then 32'h2401FFFF, o_c_core_reset high 2 cycles, o_done after 10 RUN cycles, o_cycle_count=10.
REQ-039 SHALL cover backpressure: i_byte_valid toggled randomly during 60-word load -> exactly 60 one-cycle strobes, words match stream, o_words_loaded=60.
REQ-040 SHALL cover illegal count: start, count 0 -> o_err=1, state IDLE, no o_byte_ready; then start, count 65 -> same.
REQ-041 SHALL cover abort: abort after 2 bytes of word 3 -> exactly 2 strobes, o_err=1, IDLE; abort in RUN with budget 0 -> o_done=1, o_err=0.
REQ-042 SHALL cover reset mid-operation: i_c_sys_reset during RUN at cycle 5 -> all outputs at REQ-036 values next cycle; a new session then completes normally.
REQ-043 SHALL cover boundary: count 64, budget 0 for 70000 cycles -> 64 strobes, o_cycle_count saturates at 16'hFFFF, stays in RUN.

Source files
------------

// File: rtl/c_boot_ctrl.sv
// Boot controller: assembles a little-endian byte stream into 32-bit instruction
// words, strobes them into the core, then pulses core reset and times the run.
module c_boot_ctrl #(
    parameter int unsigned RST_CYCLES = 2,
    parameter int unsigned MAX_WORDS  = 64
) (
    input  logic        i_c_sys_clock,
    input  logic        i_c_sys_reset,
    input  logic        i_start,
    input  logic [6:0]  i_word_count,
    input  logic [15:0] i_run_cycles,
    input  logic        i_abort,
    input  logic [7:0]  i_byte,
    input  logic        i_byte_valid,
    output logic        o_byte_ready,
    output logic [31:0] o_c_write_ins,
    output logic        o_c_ins_wr,
    output logic        o_c_core_reset,
    output logic        o_busy,
    output logic        o_done,
    output logic        o_err,
    output logic [6:0]  o_words_loaded,
    output logic [15:0] o_cycle_count
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_RESET_CORE,
        S_RUN,
        S_DONE
    } state_e;

    localparam logic [3:0] RST_LAST = 4'(RST_CYCLES - 1);

    state_e      state_q, state_d;
    logic [1:0]  byte_idx_q, byte_idx_d;
    logic [23:0] word_buf_q, word_buf_d;
    logic [31:0] write_ins_q, write_ins_d;
    logic        ins_wr_q, ins_wr_d;
    logic        byte_ready_q, byte_ready_d;
    logic        core_reset_q, core_reset_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        err_q, err_d;
    logic [6:0]  words_loaded_q, words_loaded_d;
    logic [15:0] cycle_count_q, cycle_count_d;
    logic [6:0]  word_count_q, word_count_d;
    logic [15:0] run_cycles_q, run_cycles_d;
    logic [3:0]  rst_cnt_q, rst_cnt_d;

    logic start_ok;
    logic sealed;
    logic byte_accept;

    assign start_ok    = (i_word_count != 7'd0) && (32'(i_word_count) <= MAX_WORDS);
    // Once the last word has been counted the load is over; the strobe cycle
    // still shows ready but any byte offered then is dropped.
    assign sealed      = (words_loaded_q == word_count_q);
    assign byte_accept = i_byte_valid && byte_ready_q && (state_q == S_LOAD) && !sealed;

    always_comb begin
        // NOTE: every variable gets its hold value first so no path infers a latch.
        state_d        = state_q;
        byte_idx_d     = byte_idx_q;
        word_buf_d     = word_buf_q;
        write_ins_d    = write_ins_q;
        ins_wr_d       = 1'b0;
        err_d          = err_q;
        words_loaded_d = words_loaded_q;
        cycle_count_d  = cycle_count_q;
        word_count_d   = word_count_q;
        run_cycles_d   = run_cycles_q;
        rst_cnt_d      = rst_cnt_q;

        case (state_q)
            S_IDLE, S_DONE: begin
                if (i_start) begin
                    if (start_ok) begin
                        state_d        = S_LOAD;
                        err_d          = 1'b0;
                        words_loaded_d = 7'd0;
                        cycle_count_d  = 16'd0;
                        byte_idx_d     = 2'd0;
                        word_count_d   = i_word_count;
                        run_cycles_d   = i_run_cycles;
                    end else begin
                        state_d = S_IDLE;
                        err_d   = 1'b1;
                    end
                end
            end
            S_LOAD: begin
                if (i_abort) begin
                    state_d    = S_IDLE;
                    err_d      = 1'b1;
                    byte_idx_d = 2'd0;
                end else if (sealed) begin
                    state_d   = S_RESET_CORE;
                    rst_cnt_d = 4'd0;
                end else if (byte_accept) begin
                    case (byte_idx_q)
                        2'd0: word_buf_d[7:0]   = i_byte;
                        2'd1: word_buf_d[15:8]  = i_byte;
                        2'd2: word_buf_d[23:16] = i_byte;
                        default: begin
                            write_ins_d    = {i_byte, word_buf_q};
                            ins_wr_d       = 1'b1;
                            words_loaded_d = words_loaded_q + 7'd1;
                        end
                    endcase
                    byte_idx_d = byte_idx_q + 2'd1;
                end
            end
            S_RESET_CORE: begin
                if (rst_cnt_q == RST_LAST) begin
                    state_d = S_RUN;
                end else begin
                    rst_cnt_d = rst_cnt_q + 4'd1;
                end
            end
            S_RUN: begin
                if (cycle_count_q != 16'hFFFF) begin
                    cycle_count_d = cycle_count_q + 16'd1;
                end
                if (i_abort) begin
                    state_d = S_DONE;
                end else if ((run_cycles_q != 16'd0) && (cycle_count_d == run_cycles_q)) begin
                    state_d = S_DONE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Status outputs are decoded from the next state so they leave flops.
        byte_ready_d = (state_d == S_LOAD);
        core_reset_d = (state_d == S_RESET_CORE);
        busy_d       = (state_d == S_LOAD) || (state_d == S_RESET_CORE) || (state_d == S_RUN);
        done_d       = (state_d == S_DONE);
    end

    always_ff @(posedge i_c_sys_clock) begin
        // NOTE: sequential state uses non-blocking assignments only.
        if (i_c_sys_reset) begin
            state_q        <= S_IDLE;
            byte_idx_q     <= 2'd0;
            word_buf_q     <= 24'd0;
            write_ins_q    <= 32'd0;
            ins_wr_q       <= 1'b0;
            byte_ready_q   <= 1'b0;
            core_reset_q   <= 1'b1;
            busy_q         <= 1'b0;
            done_q         <= 1'b0;
            err_q          <= 1'b0;
            words_loaded_q <= 7'd0;
            cycle_count_q  <= 16'd0;
            word_count_q   <= 7'd0;
            run_cycles_q   <= 16'd0;
            rst_cnt_q      <= 4'd0;
        end else begin
            state_q        <= state_d;
            byte_idx_q     <= byte_idx_d;
            word_buf_q     <= word_buf_d;
            write_ins_q    <= write_ins_d;
            ins_wr_q       <= ins_wr_d;
            byte_ready_q   <= byte_ready_d;
            core_reset_q   <= core_reset_d;
            busy_q         <= busy_d;
            done_q         <= done_d;
            err_q          <= err_d;
            words_loaded_q <= words_loaded_d;
            cycle_count_q  <= cycle_count_d;
            word_count_q   <= word_count_d;
            run_cycles_q   <= run_cycles_d;
            rst_cnt_q      <= rst_cnt_d;
        end
    end

    assign o_byte_ready   = byte_ready_q;
    assign o_c_write_ins  = write_ins_q;
    assign o_c_ins_wr     = ins_wr_q;
    assign o_c_core_reset = core_reset_q;
    assign o_busy         = busy_q;
    assign o_done         = done_q;
    assign o_err          = err_q;
    assign o_words_loaded = words_loaded_q;
    assign o_cycle_count  = cycle_count_q;

endmodule
